// File: rtl/rf_write_port_ctrl_if.sv
// Bundle of the write-back handshake, register file write/read ports and
// occupancy status used by the register file write-side front end.
interface rf_write_port_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_wb_valid;
    logic              out_wb_ready;
    logic              in_wb_en;
    logic [ADDR_W-1:0] in_wb_dest;
    logic [DATA_W-1:0] in_wb_data;
    logic              in_rf_stall;
    logic [DATA_W-1:0] out_PC;
    logic [ADDR_W-1:0] out_SC;
    logic              out_RFL;
    logic [ADDR_W-1:0] in_SA;
    logic [ADDR_W-1:0] in_SB;
    logic [DATA_W-1:0] in_PA_rf;
    logic [DATA_W-1:0] in_PB_rf;
    logic [DATA_W-1:0] out_PA_fwd;
    logic [DATA_W-1:0] out_PB_fwd;
    logic [CNT_W-1:0]  out_count;
    logic              out_empty;
    logic              out_full;

    modport slave (
        input  in_wb_valid, in_wb_en, in_wb_dest, in_wb_data, in_rf_stall,
        input  in_SA, in_SB, in_PA_rf, in_PB_rf,
        output out_wb_ready, out_PC, out_SC, out_RFL,
        output out_PA_fwd, out_PB_fwd, out_count, out_empty, out_full
    );

    modport master (
        output in_wb_valid, in_wb_en, in_wb_dest, in_wb_data, in_rf_stall,
        output in_SA, in_SB, in_PA_rf, in_PB_rf,
        input  out_wb_ready, out_PC, out_SC, out_RFL,
        input  out_PA_fwd, out_PB_fwd, out_count, out_empty, out_full
    );
endinterface

// File: rtl/rf_write_port_ctrl.sv
// Write-side front end of the register file: buffers write-back results in a
// small FIFO, drains one per cycle and forwards pending writes to both read ports.
module rf_write_port_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   in_clk,
    input  logic                   clr,
    rf_write_port_ctrl_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic empty;
    logic full;
    logic rfl;
    logic ready;
    logic push;
    logic pop;

    // A full FIFO can still take a result on the same edge its head commits.
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
        rfl   = !empty && !bus.in_rf_stall && !clr;
        ready = !clr && (!full || rfl);
        push  = bus.in_wb_valid && ready && bus.in_wb_en && (bus.in_wb_dest != '0);
        pop   = rfl;
    end

    always_ff @(posedge in_clk) begin
        if (push) begin
            data_q[wr_ptr] <= bus.in_wb_data;
            dest_q[wr_ptr] <= bus.in_wb_dest;
        end
    end

    always_ff @(posedge in_clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk from oldest to newest so the youngest matching entry overrides.
    logic [PTR_W-1:0]  idx;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        idx   = '0;
        fwd_a = bus.in_PA_rf;
        fwd_b = bus.in_PB_rf;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((bus.in_SA != '0) && (dest_q[idx] == bus.in_SA)) fwd_a = data_q[idx];
                if ((bus.in_SB != '0) && (dest_q[idx] == bus.in_SB)) fwd_b = data_q[idx];
            end
        end
    end

    assign bus.out_wb_ready = ready;
    assign bus.out_RFL      = rfl;
    assign bus.out_PC       = empty ? '0 : data_q[rd_ptr];
    assign bus.out_SC       = empty ? '0 : dest_q[rd_ptr];
    assign bus.out_PA_fwd   = fwd_a;
    assign bus.out_PB_fwd   = fwd_b;
    assign bus.out_count    = count;
    assign bus.out_empty    = empty;
    assign bus.out_full     = full;
endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Directed bench for rf_write_port_ctrl: expected commits go into a queue that a
// monitor drains whenever the register file load is asserted.
module tb_rf_write_port_ctrl;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic in_clk = 1'b0;
    logic clr;

    always #5 in_clk = ~in_clk;

    rf_write_port_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_port_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .in_clk (in_clk),
        .clr    (clr),
        .bus    (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer one result and hold it until accepted; record it if it should commit.
    task automatic applyStimulus(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                                 input logic en, input logic store);
        bit   ok;
        exp_t e;
        ok              = 1'b0;
        bus.in_wb_valid = 1'b1;
        bus.in_wb_en    = en;
        bus.in_wb_dest  = dest;
        bus.in_wb_data  = data;
        for (int k = 0; k < 20; k++) begin
            @(negedge in_clk);
            if (bus.out_wb_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL accept dest=%0d: got ready=0 expected ready=1 within 20 cycles", dest);
        end else begin
            @(posedge in_clk);
            if (store) begin
                e.dest = dest;
                e.data = data;
                exp_q.push_back(e);
            end
        end
        #1;
        bus.in_wb_valid = 1'b0;
        bus.in_wb_en    = 1'b0;
    endtask

    always @(negedge in_clk) begin
        if (bus.out_RFL) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL commit_unexpected: got RFL=1 SC=%0d expected RFL=0", bus.out_SC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("commit_sc", 32'(bus.out_SC), 32'(e.dest));
                checkOutput("commit_pc", bus.out_PC, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr             = 1'b1;
        bus.in_wb_valid = 1'b0;
        bus.in_wb_en    = 1'b0;
        bus.in_wb_dest  = '0;
        bus.in_wb_data  = '0;
        bus.in_rf_stall = 1'b0;
        bus.in_SA       = 5'd4;
        bus.in_SB       = 5'd5;
        bus.in_PA_rf    = 32'hDEAD0001;
        bus.in_PB_rf    = 32'hDEAD0002;

        @(negedge in_clk);
        checkOutput("rst_ready", 32'(bus.out_wb_ready), 32'd0);
        checkOutput("rst_rfl",   32'(bus.out_RFL),      32'd0);
        @(posedge in_clk);
        @(posedge in_clk);
        #1 clr = 1'b0;

        @(negedge in_clk);
        checkOutput("idle_count", 32'(bus.out_count), 32'd0);
        checkOutput("idle_empty", 32'(bus.out_empty), 32'd1);
        checkOutput("idle_full",  32'(bus.out_full),  32'd0);
        checkOutput("idle_pc",    bus.out_PC,         32'd0);
        checkOutput("idle_sc",    32'(bus.out_SC),    32'd0);
        checkOutput("idle_fwd_a", bus.out_PA_fwd,     32'hDEAD0001);
        checkOutput("idle_fwd_b", bus.out_PB_fwd,     32'hDEAD0002);
        checkOutput("idle_ready", 32'(bus.out_wb_ready), 32'd1);

        // Single write: visible on the write port and forwarded until committed.
        @(posedge in_clk); #1;
        applyStimulus(5'd4, 32'h4, 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("single_count", 32'(bus.out_count), 32'd1);
        checkOutput("single_rfl",   32'(bus.out_RFL),   32'd1);
        checkOutput("single_fwd_a", bus.out_PA_fwd,     32'h4);
        @(negedge in_clk);
        checkOutput("single_done_count", 32'(bus.out_count), 32'd0);
        checkOutput("single_done_empty", 32'(bus.out_empty), 32'd1);
        checkOutput("single_done_fwd_a", bus.out_PA_fwd,     32'hDEAD0001);

        // Writes to r0 and disabled writes complete but store nothing.
        @(posedge in_clk); #1;
        applyStimulus(5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        applyStimulus(5'd3, 32'h33, 1'b0, 1'b0);
        @(negedge in_clk);
        checkOutput("r0_count", 32'(bus.out_count), 32'd0);
        checkOutput("r0_empty", 32'(bus.out_empty), 32'd1);

        // Fill under stall, then drain in order.
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(5'(i), 32'(i * 32'h11), 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("fill_count", 32'(bus.out_count),    32'd4);
        checkOutput("fill_full",  32'(bus.out_full),     32'd1);
        checkOutput("fill_ready", 32'(bus.out_wb_ready), 32'd0);
        checkOutput("fill_rfl",   32'(bus.out_RFL),      32'd0);
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b0;
        repeat (5) @(negedge in_clk);
        checkOutput("drain_empty", 32'(bus.out_empty), 32'd1);
        checkOutput("drain_count", 32'(bus.out_count), 32'd0);

        // Full FIFO accepts on the same edge its head drains.
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(5'(i), 32'(i * 32'h101), 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("pp_full", 32'(bus.out_full), 32'd1);
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b0;
        applyStimulus(5'd5, 32'h55, 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("pp_count", 32'(bus.out_count), 32'd4);
        repeat (5) @(negedge in_clk);
        checkOutput("pp_empty", 32'(bus.out_empty), 32'd1);

        // Forwarding picks the newest matching entry.
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b1;
        bus.in_SA       = 5'd7;
        bus.in_SB       = 5'd7;
        bus.in_PA_rf    = 32'h1234;
        bus.in_PB_rf    = 32'h1234;
        applyStimulus(5'd7, 32'hAAAA, 1'b1, 1'b1);
        applyStimulus(5'd7, 32'hBBBB, 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("fwd_newest_a", bus.out_PA_fwd,     32'hBBBB);
        checkOutput("fwd_newest_b", bus.out_PB_fwd,     32'hBBBB);
        checkOutput("fwd_count",    32'(bus.out_count), 32'd2);
        @(posedge in_clk); #1;
        bus.in_SA = 5'd0;
        bus.in_SB = 5'd6;
        @(negedge in_clk);
        checkOutput("fwd_r0_a",     bus.out_PA_fwd, 32'h1234);
        checkOutput("fwd_nomatch_b", bus.out_PB_fwd, 32'h1234);
        @(posedge in_clk); #1;
        bus.in_SA       = 5'd7;
        bus.in_rf_stall = 1'b0;
        @(negedge in_clk);
        checkOutput("fwd_during_drain_a", bus.out_PA_fwd, 32'hBBBB);
        repeat (3) @(negedge in_clk);
        checkOutput("fwd_drained_a", bus.out_PA_fwd, 32'h1234);

        // Reset mid-operation drops pending entries.
        @(posedge in_clk); #1;
        bus.in_rf_stall = 1'b1;
        bus.in_SA       = 5'd12;
        applyStimulus(5'd10, 32'hA0, 1'b1, 1'b1);
        applyStimulus(5'd11, 32'hB0, 1'b1, 1'b1);
        applyStimulus(5'd12, 32'hC0, 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("mid_count", 32'(bus.out_count), 32'd3);
        checkOutput("mid_fwd_a", bus.out_PA_fwd,     32'hC0);
        @(posedge in_clk); #1;
        clr = 1'b1;
        exp_q.delete();
        @(negedge in_clk);
        checkOutput("clr_ready", 32'(bus.out_wb_ready), 32'd0);
        checkOutput("clr_rfl",   32'(bus.out_RFL),      32'd0);
        @(posedge in_clk); #1;
        clr             = 1'b0;
        bus.in_rf_stall = 1'b0;
        @(negedge in_clk);
        checkOutput("post_clr_count", 32'(bus.out_count), 32'd0);
        checkOutput("post_clr_rfl",   32'(bus.out_RFL),   32'd0);
        checkOutput("post_clr_fwd_a", bus.out_PA_fwd,     32'h1234);
        bus.in_SA = 5'd9;
        @(posedge in_clk); #1;
        applyStimulus(5'd9, 32'h99, 1'b1, 1'b1);
        @(negedge in_clk);
        checkOutput("post_clr_push_rfl",   32'(bus.out_RFL), 32'd1);
        checkOutput("post_clr_push_fwd_a", bus.out_PA_fwd,   32'h99);
        repeat (3) @(negedge in_clk);
        checkOutput("final_empty",   32'(bus.out_empty), 32'd1);
        checkOutput("final_pending", 32'(exp_q.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_write_port_ctrl.md
Name: rf_write_port_ctrl

Overview:
- Write-side front end for the 32x32 register file.
- Accepts write-back results from the pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (data PC, select SC, load RFL).
- Provides forwarding on both read ports, so reads see pending, not-yet-committed writes.

Parameters:
DEPTH, 4, number of pending-write FIFO entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register select width

Ports:
in_clk  input  1  clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
in_wb_valid  input  1  write-back result offered this cycle
out_wb_ready  output  1  controller can accept the offered result
in_wb_en  input  1  result carries a register write (RegWrite)
in_wb_dest  input  ADDR_W  destination register
in_wb_data  input  DATA_W  result value
in_rf_stall  input  1  write port unavailable this cycle; hold head
out_PC  output  DATA_W  register file write data
out_SC  output  ADDR_W  register file write select
out_RFL  output  1  register file load enable
in_SA  input  ADDR_W  read port A select (shared with register file)
in_SB  input  ADDR_W  read port B select
in_PA_rf  input  DATA_W  raw register file port A data
in_PB_rf  input  DATA_W  raw register file port B data
out_PA_fwd  output  DATA_W  forwarded port A data
out_PB_fwd  output  DATA_W  forwarded port B data
out_count  output  clog2(DEPTH)+1  pending entries
out_empty  output  1  count==0
out_full  output  1  count==DEPTH

Behaviour:
- Reset: clr synchronous and active-high. On the edge with clr=1, the FIFO empties (pointers and count = 0); in-flight handshakes are dropped.
- While clr=1: out_wb_ready=0 and out_RFL=0.
- Idle values: out_PC=0, out_SC=0, out_count=0, out_empty=1, out_full=0. Forwarded outputs pass in_PA_rf/in_PB_rf.
- Accept: a transfer occurs on an edge where in_wb_valid && out_wb_ready.
  - Enqueue only if in_wb_en=1 and in_wb_dest!=0.
  - Otherwise the transfer completes but nothing is stored (r0 is hardwired zero).
- Drain (combinational from state): out_RFL = !out_empty && !in_rf_stall && !clr.
  - out_PC/out_SC = head entry when non-empty, else 0.
  - Head pops on any edge where out_RFL=1; the register file latches the same edge.
- Ready: out_wb_ready = !clr && (!out_full || out_RFL). A full FIFO accepts while it drains.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: result accepted at edge N into an empty FIFO with no stall → out_RFL=1 during cycle N..N+1 → committed at edge N+1. Each stall cycle adds one cycle.
- Forwarding (combinational): out_PA_fwd = data of the newest valid entry whose dest==in_SA, including the head being drained this cycle. Same rule for B.
  - in_SA==0 or no match: pass in_PA_rf.
  - Multiple entries with the same dest: the newest (closest to tail) wins.
  - The incoming (not yet stored) in_wb_* is NOT forwarded.
- No overflow or underflow: pushes are blocked by ready; pops are gated by empty.
- Driving in_wb_valid with in_wb_en=0 never alters FIFO state.

Test Plan:
- Reset then single write: clr 2 cycles; offer dest=4, data=0x00000004, en=1 → accepted, out_RFL=1, out_SC=4, out_PC=0x4 for exactly one cycle. count returns to 0; out_PA_fwd with SA=4 = 0x4 before commit.
- r0 / disabled writes: offer dest=0 data=0xFFFFFFFF en=1, then dest=3 en=0 → both accepted (ready=1), out_RFL never asserts, count stays 0.
- Fill under stall: in_rf_stall=1, push dest=1..4 data=0x11,0x22,0x33,0x44 → count=4, out_full=1, out_wb_ready=0. Release stall → SC 1,2,3,4 in order on consecutive cycles, then out_empty=1.
- Full with simultaneous push/pop: FIFO full, stall=0, offer dest=5 data=0x55 → accepted the same edge dest=1 drains, count stays 4, 0x55 commits fifth.
- Forwarding priority: stall=1, push dest=7 data=0xAAAA then dest=7 data=0xBBBB; SA=7, SB=7, in_PA_rf=in_PB_rf=0x1234 → both fwd outputs = 0xBBBB. SA=0 → 0x1234.
- Reset mid-operation: 3 entries pending with stall=1, assert clr one cycle → next cycle count=0, out_RFL=0, fwd outputs equal rf inputs; subsequent push of dest=9 data=0x99 commits normally.
